nor_sweep_ctrl: RTL and testbench
=================================

Name: nor_sweep_ctrl

Overview:
Sequencer that drives a four-input NOR gate under test (inputs a,b,c,d; three observed outputs e,f,g) through all 16 input combinations. It waits a programmable settle time per vector, samples e/f/g and checks each against the NOR of the applied vector. It reports a pass/fail summary, an error count and the first failing vector. It replaces free-running toggle stimulus with a deterministic, self-checking exhaustive sweep.

Parameters:
SETTLE_CYC, 2, clock cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  sweep request; sampled only in IDLE or DONE.
e  input  1  DUT output 0, expected ~(a|b|c|d).
f  input  1  DUT output 1, expected ~(a|b|c|d).
g  input  1  DUT output 2, expected ~(a|b|c|d).
a  output  1  DUT input, vec[3].
b  output  1  DUT input, vec[2].
c  output  1  DUT input, vec[1].
d  output  1  DUT input, vec[0].
busy  output  1  high from the cycle after start is accepted until done rises.
done  output  1  high in DONE; held until next start.
pass  output  1  valid while done=1: 1 iff err_cnt==0.
err_cnt  output  5  number of mismatching vectors, 0..16; a vector with several failing outputs counts once.
fail_vec  output  4  first failing vector {a,b,c,d}; 0 if none.
fail_mask  output  3  {e,f,g} mismatch bits for fail_vec; 0 if none.

Behaviour:
- One clock domain; rst_n is asynchronous active-low and may assert at any time.
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_mask=0; state=IDLE.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: outputs a..d=0. start=1 -> SETTLE; vec=0; settle counter=0; clear err_cnt, fail_vec, fail_mask, done, pass; busy=1.
- SETTLE: {a,b,c,d}=vec, registered. Counter increments each cycle; after SETTLE_CYC cycles in SETTLE -> SAMPLE.
- SAMPLE (exactly 1 cycle): exp=~|vec. mism={e^exp,f^exp,g^exp}. If mism!=0: err_cnt+=1; if this is the first error, capture fail_vec=vec and fail_mask=mism. If vec==15 -> DONE; else vec+=1, counter=0 -> SETTLE.
- Each vector occupies exactly SETTLE_CYC+1 cycles. done rises 16*(SETTLE_CYC+1) cycles after the edge that accepted start. busy falls on the same edge.
- DONE: done=1; pass=(err_cnt==0). a..d hold the last vector (1111). Results hold until the next start. start=1 in DONE behaves as in IDLE: results clear and a new sweep begins.
- start while busy is ignored; there is no abort input.
- err_cnt cannot exceed 16; the 5-bit width holds 16 without wrap.
- vec is 4-bit. Increment happens only when vec<15, so there is no wrap.
- Reset mid-sweep: all outputs and state return to reset values immediately (asynchronously); the partial sweep is discarded.
- e/f/g are sampled only in SAMPLE. Values in SETTLE are ignored, so glitches during settle are not errors.

Test Plan:
- Good DUT model, SETTLE_CYC=2, start pulse -> a..d step 0000..1111, each held 3 cycles; done rises 48 cycles after start; pass=1, err_cnt=0, fail_vec=0, fail_mask=0.
- f stuck-at-0 -> only vector 0000 fails; err_cnt=1, fail_vec=0000, fail_mask=010, pass=0.
- e stuck-at-1 and g inverted (g=a|b|c|d) -> e fails 15 vectors and g fails all 16; err_cnt=16, fail_vec=0000, fail_mask=001 (e correct at 0000), pass=0.
- start re-pulsed mid-sweep at vector 5 -> ignored; sweep completes at cycle 48; start in DONE -> results clear and a new sweep begins with busy=1.
- rst_n pulsed low asynchronously between edges during vector 9 -> all outputs 0 immediately; state IDLE; next start runs a full 16-vector sweep.
- SETTLE_CYC=1 and SETTLE_CYC=15 builds -> done latency 32 and 256 cycles respectively; a..d change only on vector boundaries.

Source files
------------

// File: rtl/nor_sweep_ctrl.sv
// Exhaustive sweep sequencer for a four-input NOR gate with three observed outputs.
// Each vector is held SETTLE_CYC cycles, sampled once, and mismatches are tallied.
module nor_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [2:0] fail_mask
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [3:0] fvec_q, fvec_d;
  logic [2:0] fmask_q, fmask_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       exp_out;
  logic [2:0] mism;

  assign exp_out = ~|vec_q;
  assign mism    = {e ^ exp_out, f ^ exp_out, g ^ exp_out};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StSettle;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 5'd0;
          fvec_d  = 4'd0;
          fmask_d = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (mism != 3'd0) begin
          err_d = err_q + 5'd1;
          // Only the first failing vector is recorded.
          if (err_q == 5'd0) begin
            fvec_d  = vec_q;
            fmask_d = mism;
          end
        end
        if (vec_q == 4'd15) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 5'd0) && (mism == 3'd0);
        end else begin
          state_d = StSettle;
          vec_d   = vec_q + 4'd1;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
      fvec_q  <= 4'd0;
      fmask_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // vec_q is zero in IDLE, so the gate inputs follow it directly.
  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_q;
  assign fail_vec     = fvec_q;
  assign fail_mask    = fmask_q;

endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// Scoreboard bench for nor_sweep_ctrl: three builds (SETTLE_CYC 2, 1, 15) with a
// faultable NOR model on the first.
module tb_nor_sweep_ctrl;

  typedef struct packed {
    logic [4:0] err;
    logic [3:0] fvec;
    logic [2:0] fmask;
    logic       pass;
    int         lat;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  int         fault;
  int         sel;
  int         tests;
  int         fails;
  sb_t        sb[$];

  logic [3:0] vec_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [4:0] err_w   [3];
  logic [3:0] fvec_w  [3];
  logic [2:0] fmask_w [3];

  logic [3:0] obs_vec;
  logic       obs_busy, obs_done, obs_pass;
  logic [4:0] obs_err;
  logic [3:0] obs_fvec;
  logic [2:0] obs_fmask;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int unsigned SC = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
    logic a, b, c, d, e, f, g, nv;
    logic busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] fail_vec;
    logic [2:0] fail_mask;

    assign nv = ~(a | b | c | d);
    assign e  = (gi == 0 && fault == 2) ? 1'b1 : nv;
    assign f  = (gi == 0 && fault == 1) ? 1'b0 : nv;
    assign g  = (gi == 0 && fault == 2) ? ~nv : nv;

    nor_sweep_ctrl #(.SETTLE_CYC(SC)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[gi]),
      .e        (e),
      .f        (f),
      .g        (g),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_cnt  (err_cnt),
      .fail_vec (fail_vec),
      .fail_mask(fail_mask)
    );

    assign vec_w[gi]   = {a, b, c, d};
    assign busy_w[gi]  = busy;
    assign done_w[gi]  = done;
    assign pass_w[gi]  = pass;
    assign err_w[gi]   = err_cnt;
    assign fvec_w[gi]  = fail_vec;
    assign fmask_w[gi] = fail_mask;
  end

  always_comb begin
    obs_vec   = vec_w[sel];
    obs_busy  = busy_w[sel];
    obs_done  = done_w[sel];
    obs_pass  = pass_w[sel];
    obs_err   = err_w[sel];
    obs_fvec  = fvec_w[sel];
    obs_fmask = fmask_w[sel];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent gate model: applies the fault to each vector and tallies the outcome.
  function automatic sb_t model(input int flt, input int s);
    sb_t r;
    logic nv, e, f, g;
    logic [2:0] m;
    r = '0;
    for (int v = 0; v < 16; v++) begin
      nv = (v == 0);
      e  = (flt == 2) ? 1'b1 : nv;
      f  = (flt == 1) ? 1'b0 : nv;
      g  = (flt == 2) ? ~nv : nv;
      m  = {e ^ nv, f ^ nv, g ^ nv};
      if (m != 3'd0) begin
        if (r.err == 5'd0) begin
          r.fvec  = 4'(v);
          r.fmask = m;
        end
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 5'd0);
    r.lat  = 16 * (s + 1);
    return r;
  endfunction

  task automatic do_start(input int idx, input logic push, input sb_t exp);
    @(negedge clk);
    start[idx] = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
  endtask

  // Called #1 after the accepting edge; follows the sweep until done or a cycle budget.
  task automatic run_sweep(input int s, input int mid);
    int   j;
    int   bad_busy;
    logic seen;
    sb_t  exp;
    j = 0;
    bad_busy = 0;
    seen = 1'b0;
    while (!seen && j <= 16 * (s + 1) + 8) begin
      if (obs_done) begin
        seen = 1'b1;
      end else begin
        if (j < 16 * (s + 1)) begin
          check("vec", 32'(obs_vec), 32'(j / (s + 1)));
          if (!obs_busy) bad_busy++;
        end
        start[sel] = (j == mid);
        @(posedge clk);
        #1;
        j++;
      end
    end
    start[sel] = 1'b0;
    check("busy_during_sweep", 32'(bad_busy), 32'd0);
    check("done_seen", 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check("latency", 32'(j), 32'(exp.lat));
      check("err_cnt", 32'(obs_err), 32'(exp.err));
      check("fail_vec", 32'(obs_fvec), 32'(exp.fvec));
      check("fail_mask", 32'(obs_fmask), 32'(exp.fmask));
      check("pass", 32'(obs_pass), 32'(exp.pass));
    end
    check("busy_at_done", 32'(obs_busy), 32'd0);
    check("last_vec", 32'(obs_vec), 32'd15);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 3'b000;
    fault = 0;
    sel   = 0;
    tests = 0;
    fails = 0;

    #12;
    check("rst_outputs", {obs_vec, obs_busy, obs_done, obs_pass, obs_err, obs_fvec, obs_fmask},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", {obs_vec, obs_busy, obs_done}, 32'd0);

    // Good gate
    do_start(0, 1'b1, model(0, 2));
    check("busy_after_start", 32'(obs_busy), 32'd1);
    run_sweep(2, -1);

    // f stuck-at-0
    fault = 1;
    do_start(0, 1'b1, model(1, 2));
    run_sweep(2, -1);

    // e stuck-at-1, g inverted
    fault = 2;
    do_start(0, 1'b1, model(2, 2));
    run_sweep(2, -1);

    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'(obs_done), 32'd1);
    check("err_hold", 32'(obs_err), 32'd16);
    check("vec_hold", 32'(obs_vec), 32'd15);

    // Restart from DONE clears results; a mid-sweep start at vector 5 is ignored.
    fault = 0;
    do_start(0, 1'b1, model(0, 2));
    check("restart_busy", 32'(obs_busy), 32'd1);
    check("restart_clear", {obs_done, obs_pass, obs_err, obs_fvec, obs_fmask}, 32'd0);
    run_sweep(2, 5 * 3 + 1);

    // Asynchronous reset between edges during vector 9
    do_start(0, 1'b0, model(0, 2));
    repeat (28) @(posedge clk);
    #1;
    check("pre_reset_vec", 32'(obs_vec), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {obs_vec, obs_busy, obs_done, obs_pass, obs_err, obs_fvec, obs_fmask},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", {obs_vec, obs_busy, obs_done}, 32'd0);
    do_start(0, 1'b1, model(0, 2));
    run_sweep(2, -1);

    // Other settle builds
    sel = 1;
    do_start(1, 1'b1, model(0, 1));
    run_sweep(1, -1);
    sel = 2;
    do_start(2, 1'b1, model(0, 15));
    run_sweep(15, -1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
